// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register list low-to-high, issuing one
// memory request and one register-file access per listed register, with optional base writeback.
module ldm_stm_seq #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          is_load_i,
  input  logic [15:0]   reg_list_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [3:0]    rn_i,
  input  logic          incr_i,
  input  logic          before_i,
  input  logic          wback_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [3:0]    rf_r_addr_o,
  input  logic [DW-1:0] rf_r_data_i,
  output logic          rf_write_reg_o,
  output logic [3:0]    rf_w_addr_o,
  output logic [DW-1:0] rf_w_data_o,
  output logic          rf_write_pc_o,
  output logic [DW-1:0] rf_pc_data_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned NREG = 16;
  localparam int unsigned CW   = 5;
  localparam int unsigned RW   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               load_q, load_d;
  logic               incr_q, incr_d;
  logic               before_q, before_d;
  logic               wback_q, wback_d;
  logic [NREG-1:0]    list_q, list_d;
  logic [NREG-1:0]    rem_q, rem_d;
  logic [AW-1:0]      base_q, base_d;
  logic [RW-1:0]      rn_q, rn_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      final_q, final_d;
  logic               empty_q, empty_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [CW-1:0]      cnt_c;
  logic [RW-1:0]      cur_c;
  logic [AW-1:0]      span_c;

  // Number of registers in the latched list
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_c = cnt_c + CW'(list_q[i]);
    end
  end

  // Lowest register still pending
  always_comb begin
    cur_c = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (rem_q[i]) cur_c = RW'(i);
    end
  end

  assign span_c = AW'(cnt_c) << 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      incr_q   <= 1'b0;
      before_q <= 1'b0;
      wback_q  <= 1'b0;
      list_q   <= '0;
      rem_q    <= '0;
      base_q   <= '0;
      rn_q     <= '0;
      addr_q   <= '0;
      final_q  <= '0;
      empty_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      incr_q   <= incr_d;
      before_q <= before_d;
      wback_q  <= wback_d;
      list_q   <= list_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
      rn_q     <= rn_d;
      addr_q   <= addr_d;
      final_q  <= final_d;
      empty_q  <= empty_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_d         = load_q;
    incr_d         = incr_q;
    before_d       = before_q;
    wback_d        = wback_q;
    list_d         = list_q;
    rem_d          = rem_q;
    base_d         = base_q;
    rn_d           = rn_q;
    addr_d         = addr_q;
    final_d        = final_q;
    empty_d        = empty_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    busy_o         = (state_q != S_IDLE);
    rf_r_addr_o    = '0;
    rf_write_reg_o = 1'b0;
    rf_w_addr_o    = '0;
    rf_w_data_o    = '0;
    rf_write_pc_o  = 1'b0;
    rf_pc_data_o   = '0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load_d   = is_load_i;
          incr_d   = incr_i;
          before_d = before_i;
          wback_d  = wback_i;
          list_d   = reg_list_i;
          rem_d    = reg_list_i;
          base_d   = base_addr_i;
          rn_d     = rn_i;
          state_d  = S_SETUP;
        end
      end

      // Transfers always ascend, so decrementing modes start at the bottom of the block
      S_SETUP: begin
        final_d = incr_q ? (base_q + span_c) : (base_q - span_c);
        if (incr_q) begin
          addr_d = before_q ? (base_q + AW'(4)) : base_q;
        end else begin
          addr_d = before_q ? (base_q - span_c) : (base_q - span_c + AW'(4));
        end
        empty_d = (cnt_c == '0);
        state_d = (cnt_c == '0) ? S_DONE : S_XFER;
      end

      S_XFER: begin
        mem_req_o  = 1'b1;
        mem_we_o   = !load_q;
        mem_addr_o = addr_q;
        if (!load_q) begin
          rf_r_addr_o = cur_c;
          mem_wdata_o = rf_r_data_i;
        end
        if (mem_ack_i) begin
          if (load_q) begin
            if (cur_c == RW'(15)) begin
              rf_write_pc_o = 1'b1;
              rf_pc_data_o  = mem_rdata_i;
            end else begin
              rf_write_reg_o = 1'b1;
              rf_w_addr_o    = cur_c;
              rf_w_data_o    = mem_rdata_i;
            end
          end
          rem_d  = rem_q & ~(NREG'(1) << cur_c);
          addr_d = addr_q + AW'(4);
          // A loaded base register takes precedence over the writeback value
          if (rem_d == '0) begin
            state_d = (wback_q && !(load_q && list_q[rn_q])) ? S_WB : S_DONE;
          end
        end
      end

      S_WB: begin
        if (rn_q == RW'(15)) begin
          rf_write_pc_o = 1'b1;
          rf_pc_data_o  = DW'(final_q);
        end else begin
          rf_write_reg_o = 1'b1;
          rf_w_addr_o    = rn_q;
          rf_w_data_o    = DW'(final_q);
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        err_d   = empty_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: stimulus pushes expected memory, register-file and
// completion events; an independent monitor pops and compares as the DUT produces them.
module tb_ldm_stm_seq;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, is_load_i, incr_i, before_i, wback_i;
  logic [15:0]   reg_list_i;
  logic [AW-1:0] base_addr_i;
  logic [3:0]    rn_i;
  logic          busy_o, done_o, err_o;
  logic [3:0]    rf_r_addr_o;
  logic [DW-1:0] rf_r_data_i;
  logic          rf_write_reg_o, rf_write_pc_o;
  logic [3:0]    rf_w_addr_o;
  logic [DW-1:0] rf_w_data_o, rf_pc_data_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  ldm_stm_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_load_i(is_load_i),
    .reg_list_i(reg_list_i), .base_addr_i(base_addr_i), .rn_i(rn_i), .incr_i(incr_i),
    .before_i(before_i), .wback_i(wback_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rf_r_addr_o(rf_r_addr_o), .rf_r_data_i(rf_r_data_i), .rf_write_reg_o(rf_write_reg_o),
    .rf_w_addr_o(rf_w_addr_o), .rf_w_data_o(rf_w_data_o), .rf_write_pc_o(rf_write_pc_o),
    .rf_pc_data_o(rf_pc_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic pc; logic [3:0] addr; logic [31:0] data; } rf_exp_t;
  typedef struct { logic err; int cyc; } done_exp_t;

  mem_exp_t    exp_mem[$];
  rf_exp_t     exp_rf[$];
  done_exp_t   exp_done[$];
  logic [31:0] regs [16];
  logic [31:0] mem_ov [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ack_mode = 0;
  int          fix_dly = 0;

  assign rf_r_data_i = regs[rf_r_addr_o];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flush();
    exp_mem.delete();
    exp_rf.delete();
    exp_done.delete();
  endtask

  // Memory responder: per-request ack delay chosen by ack_mode
  initial begin
    int wcnt;
    wcnt = -1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      if (!rst_n || !mem_req_o) begin
        wcnt = -1;
      end else begin
        if (wcnt < 0) wcnt = (ack_mode == 0) ? 0 : (ack_mode == 2) ? fix_dly : int'($urandom_range(0, 3));
        if (wcnt == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_rd(mem_addr_o);
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor
  initial begin
    logic        prev_stall;
    logic [64:0] prev_req;
    mem_exp_t    me;
    rf_exp_t     re;
    done_exp_t   de;
    prev_stall = 1'b0;
    prev_req = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (mem_req_o && prev_stall) check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, prev_req);
        if (mem_req_o && mem_ack_i) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected", {1'b1, mem_addr_o}, 0);
          end else begin
            me = exp_mem.pop_front();
            check("mem_addr", mem_addr_o, me.addr);
            check("mem_we", mem_we_o, me.we);
            if (me.we) check("mem_wdata", mem_wdata_o, me.wdata);
          end
        end
        if (rf_write_reg_o || rf_write_pc_o) begin
          if (exp_rf.size() == 0) begin
            check("rf_unexpected", {rf_write_pc_o, rf_write_reg_o, rf_w_addr_o}, 0);
          end else begin
            re = exp_rf.pop_front();
            check("rf_kind", {rf_write_pc_o, rf_write_reg_o}, {re.pc, !re.pc});
            if (re.pc) check("rf_pc_data", rf_pc_data_o, re.data);
            else check("rf_w", {rf_w_addr_o, rf_w_data_o}, {re.addr, re.data});
          end
        end
        if (done_o) begin
          if (exp_done.size() == 0) begin
            check("done_unexpected", done_o, 0);
          end else begin
            de = exp_done.pop_front();
            check("done_err", err_o, de.err);
            if (de.cyc >= 0) check("done_cycle", cyc, de.cyc);
          end
        end else if (err_o) begin
          check("err_without_done", err_o, 0);
        end
        prev_stall = mem_req_o && !mem_ack_i;
        prev_req = {mem_we_o, mem_addr_o, mem_wdata_o};
      end
    end
  end

  // Reference: listed registers occupy a contiguous ascending block starting at 'lo'
  task automatic issue(input logic ld, input logic [15:0] list, input logic [31:0] base,
                       input logic [3:0] rn, input logic inc, input logic bef, input logic wb);
    int          idx[$];
    int          n, per;
    logic [31:0] lo, fin, a;
    logic        do_wb;
    mem_exp_t    me;
    rf_exp_t     re;
    done_exp_t   de;
    for (int i = 0; i < 16; i++) if (list[i]) idx.push_back(i);
    n = idx.size();
    fin = inc ? base + 32'(4 * n) : base - 32'(4 * n);
    lo = inc ? base + (bef ? 32'd4 : 32'd0) : fin + (bef ? 32'd0 : 32'd4);
    for (int k = 0; k < n; k++) begin
      a = lo + 32'(4 * k);
      me.addr = a;
      me.we = !ld;
      me.wdata = ld ? 32'h0 : regs[idx[k]];
      exp_mem.push_back(me);
      if (ld) begin
        re.pc = (idx[k] == 15);
        re.addr = 4'(idx[k]);
        re.data = mem_rd(a);
        exp_rf.push_back(re);
      end
    end
    do_wb = wb && (n != 0) && !(ld && list[rn]);
    if (do_wb) begin
      re.pc = (rn == 4'd15);
      re.addr = rn;
      re.data = fin;
      exp_rf.push_back(re);
    end
    per = (ack_mode == 0) ? 1 : (ack_mode == 2) ? 1 + fix_dly : -1;
    de.err = (n == 0);
    de.cyc = (per < 0) ? -1 : cyc + 3 + n * per + (do_wb ? 1 : 0);
    exp_done.push_back(de);
    start_i = 1'b1;
    is_load_i = ld;
    reg_list_i = list;
    base_addr_i = base;
    rn_i = rn;
    incr_i = inc;
    before_i = bef;
    wback_i = wb;
    @(posedge clk); #1;
    start_i = 1'b0;
    reg_list_i = 16'($urandom);
    base_addr_i = $urandom;
    is_load_i = 1'($urandom);
    rn_i = 4'($urandom);
  endtask

  // Wait for idle with all expectations consumed; pokes start while busy, which must be ignored
  task automatic wait_idle();
    int t;
    t = 0;
    while (1) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (!busy_o && exp_mem.size() == 0 && exp_rf.size() == 0 && exp_done.size() == 0) break;
      if (busy_o) begin
        start_i = 1'($urandom_range(0, 1));
        reg_list_i = 16'($urandom);
        base_addr_i = $urandom;
        is_load_i = 1'($urandom);
        wback_i = 1'($urandom);
      end
      t++;
      if (t > 400) begin
        check("idle_timeout", {busy_o, 32'(exp_mem.size() + exp_rf.size() + exp_done.size())}, 0);
        flush();
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] list;
    rst_n = 1'b0;
    start_i = 1'b0; is_load_i = 1'b0; incr_i = 1'b0; before_i = 1'b0; wback_i = 1'b0;
    reg_list_i = '0; base_addr_i = '0; rn_i = '0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy_o, done_o, err_o, rf_write_reg_o, rf_write_pc_o, mem_req_o, mem_we_o}, 0);
    check("rst_data", {rf_r_addr_o, rf_w_addr_o, rf_w_data_o | rf_pc_data_o | mem_addr_o | mem_wdata_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ack_mode = 0;
    regs[0] = 32'hA; regs[2] = 32'hB; regs[15] = 32'hC;
    issue(1'b0, 16'h8005, 32'h100, 4'd0, 1'b1, 1'b0, 1'b0); wait_idle();
    issue(1'b1, 16'h00F0, 32'h200, 4'd13, 1'b0, 1'b1, 1'b1); wait_idle();
    mem_ov[32'h40] = 32'h11; mem_ov[32'h44] = 32'h22;
    issue(1'b1, 16'h0003, 32'h40, 4'd1, 1'b1, 1'b0, 1'b1); wait_idle();
    ack_mode = 2; fix_dly = 2;
    issue(1'b0, 16'h0010, 32'h80, 4'd3, 1'b1, 1'b1, 1'b0); wait_idle();
    ack_mode = 0;
    issue(1'b1, 16'h8000, 32'h300, 4'd2, 1'b1, 1'b0, 1'b0); wait_idle();
    issue(1'b1, 16'h0000, 32'h300, 4'd2, 1'b1, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 16'h0006, 32'h1000, 4'd15, 1'b0, 1'b0, 1'b1); wait_idle();
    issue(1'b0, 16'hFFFF, 32'h8, 4'd0, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(1'b0, 16'h2001, 32'h500, 4'd13, 1'b1, 1'b1, 1'b1); wait_idle();

    for (int r = 0; r < 60; r++) begin
      ack_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      case ($urandom_range(0, 7))
        0:       list = 16'h0000;
        1, 2:    list = 16'(1) << $urandom_range(0, 15);
        default: list = 16'($urandom);
      endcase
      issue(1'($urandom), list, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      wait_idle();
    end

    // Reset in the middle of a long transfer
    ack_mode = 1;
    issue(1'b1, 16'hFFFF, $urandom, 4'd5, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_req", mem_req_o, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {busy_o, done_o, err_o, rf_write_reg_o, rf_write_pc_o, mem_req_o, mem_we_o}, 0);
    check("midrst_data", {rf_r_addr_o, rf_w_addr_o, rf_w_data_o | rf_pc_data_o | mem_addr_o | mem_wdata_o}, 0);
    flush();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack_mode = 0;
    issue(1'b0, 16'h0421, 32'h2000, 4'd4, 1'b0, 1'b0, 1'b1); wait_idle();

    check("queues_drained", 32'(exp_mem.size() + exp_rf.size() + exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
